ref_window_loader: RTL and testbench

Assembles the 15×15 integer-pixel reference window consumed by the subpixel interpolation datapath from a narrow pixel stream. Accepts 8 pixels per beat over a valid/ready input, packs them row-major into the 1800-bit window buffer, and presents the completed window to the interpolator with a valid/ready handoff. It sits between the reference-frame fetch path and the interpolator's `in_buffer` input, and is the writer side of that buffer.

---
 rtl/ref_window_loader.sv | 120 ++++++++++++
 tb/tb_ref_window_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_window_loader.sv
// Packs an 8-pixel-per-beat stream row-major into a 15x15 reference window
// and hands the completed window to the interpolator over valid/ready.
module ref_window_loader #(
  parameter int PIXEL_W  = 8,
  parameter int WIN_DIM  = 15,
  parameter int BEAT_PIX = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [BEAT_PIX*PIXEL_W-1:0]          in_data,
  input  logic                                 in_valid,
  input  logic                                 in_sof,
  output logic                                 in_ready,
  output logic [WIN_DIM*WIN_DIM*PIXEL_W-1:0]   win_buffer,
  output logic                                 win_valid,
  input  logic                                 win_ready,
  output logic [4:0]                           fill_cnt,
  output logic                                 sync_err,
  output logic                                 dbg_state
);

  // Handshake: a beat transfers on a rising edge where in_valid & in_ready;
  // a window transfers on a rising edge where win_valid & win_ready.

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  localparam logic [4:0] LAST_BEAT = 5'(2 * WIN_DIM - 1);

  state_t                                   r_state;
  state_t                                   w_next_state;
  logic [4:0]                               r_fill_cnt;
  logic [4:0]                               w_next_cnt;
  logic                                     r_sync_err;
  logic [WIN_DIM-1:0][WIN_DIM-1:0][PIXEL_W-1:0] r_win;

  logic                                     w_in_ready;
  logic                                     w_win_valid;
  logic                                     w_accept;
  logic                                     w_restart;
  logic [4:0]                               w_beat_idx;
  logic [3:0]                               w_row;
  logic [WIN_DIM-1:0][PIXEL_W-1:0]          w_col_data;
  logic [WIN_DIM-1:0]                       w_col_we;

  assign w_accept   = in_valid & (r_state == S_FILL);
  // An sof beat arriving mid-fill abandons the partial window and becomes beat 0.
  assign w_restart  = w_accept & in_sof & (r_fill_cnt != 5'd0);
  assign w_beat_idx = w_restart ? 5'd0 : r_fill_cnt;
  assign w_row      = w_beat_idx[4:1];

  // Half 0 writes columns 0..7 from lanes 0..7; half 1 writes 8..14 from lanes 0..6.
  always_comb begin
    w_col_data = '0;
    w_col_we   = '0;
    for (int c = 0; c < WIN_DIM; c++) begin
      w_col_data[c] = in_data[(c % BEAT_PIX)*PIXEL_W +: PIXEL_W];
      w_col_we[c]   = w_accept & (w_beat_idx[0] ? (c >= BEAT_PIX) : (c < BEAT_PIX));
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_fill_cnt;
    w_in_ready   = 1'b0;
    w_win_valid  = 1'b0;
    case (r_state)
      S_FILL: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          if (w_restart) begin
            w_next_cnt = 5'd1;
          end else if (r_fill_cnt == LAST_BEAT) begin
            w_next_cnt   = 5'd0;
            w_next_state = S_FULL;
          end else begin
            w_next_cnt = r_fill_cnt + 5'd1;
          end
        end
      end
      S_FULL: begin
        w_win_valid = 1'b1;
        if (win_ready) w_next_state = S_FILL;
      end
      default: w_next_state = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FILL;
      r_fill_cnt <= 5'd0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_fill_cnt <= w_next_cnt;
      r_sync_err <= w_restart;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win <= '0;
    end else begin
      for (int c = 0; c < WIN_DIM; c++) begin
        if (w_col_we[c]) r_win[w_row][c] <= w_col_data[c];
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign win_valid  = w_win_valid;
  assign win_buffer = r_win;
  assign fill_cnt   = r_fill_cnt;
  assign sync_err   = r_sync_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ref_window_loader.sv
// Directed bench for ref_window_loader: table-driven handshake vectors plus
// hand-written window, handoff, gap, restart and reset sequences.
module tb_ref_window_loader;

  logic          clk;
  logic          rst;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic [1799:0] win_buffer;
  logic          win_valid;
  logic          win_ready;
  logic [4:0]    fill_cnt;
  logic          sync_err;
  logic          dbg_state;

  int checks;
  int failures;

  ref_window_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .win_buffer(win_buffer),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .fill_cnt  (fill_cnt),
    .sync_err  (sync_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       valid;
    logic       sof;
    logic       wready;
    logic [4:0] exp_cnt;
    logic       exp_sync;
    logic       exp_wvalid;
    logic       exp_iready;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pat(input int b);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'((b * 8 + k) & 255);
    return d;
  endfunction

  function automatic logic [7:0] exp_pix(input int r, input int c, input bit a5);
    int b;
    if (a5 && r == 0 && c < 8) return 8'hA5;
    b = 2 * r + ((c >= 8) ? 1 : 0);
    return 8'((b * 8 + (c % 8)) & 255);
  endfunction

  // scoreboard over the whole window; one comparison per call
  task automatic check_window(input string name, input bit a5);
    int bad;
    int fr, fc;
    logic [7:0] act, ex, fa, fe;
    bad = 0; fr = 0; fc = 0; fa = 0; fe = 0;
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 15; c++) begin
        act = win_buffer[(r*15+c)*8 +: 8];
        ex  = exp_pix(r, c, a5);
        if (act !== ex) begin
          if (bad == 0) begin fr = r; fc = c; fa = act; fe = ex; end
          bad++;
        end
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s %0d bad pixels, first (%0d,%0d) actual=%0h expected=%0h",
               name, bad, fr, fc, fa, fe);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),    32'd1);
    chk({tag, "_win_valid"}, 32'(win_valid),   32'd0);
    chk({tag, "_fill_cnt"},  32'(fill_cnt),    32'd0);
    chk({tag, "_sync_err"},  32'(sync_err),    32'd0);
    chk({tag, "_buf_zero"},  32'(|win_buffer), 32'd0);
  endtask

  // driver: consecutive beats first..first+n-1, sof on the first if requested
  task automatic feed_beats(input int first, input int n, input bit sof_first);
    for (int j = 0; j < n; j++) begin
      in_valid = 1'b1;
      in_data  = pat(first + j);
      in_sof   = sof_first && (j == 0);
      tick();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic handoff();
    win_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    win_ready = 1'b0;
    chk("handoff_wvalid", 32'(win_valid), 32'd0);
  endtask

  initial begin
    int cnt;
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    win_ready = 1'b0;

    // handshake vectors from an empty window: gaps, optional sof, restarts
    vecs[0] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1};

    // reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sof    = 1'($urandom_range(0, 1));
      win_ready = 1'($urandom_range(0, 1));
      in_data   = {$urandom(), $urandom()};
      tick();
      check_reset_state("rst_hold");
    end
    chk("rst_state", 32'(dbg_state), 32'd0);
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    win_ready = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_reset_state("rst_release");

    // table-driven handshake vectors
    for (int i = 0; i < 10; i++) begin
      in_valid  = vecs[i].valid;
      in_sof    = vecs[i].sof;
      win_ready = vecs[i].wready;
      in_data   = pat(i);
      tick();
      chk($sformatf("vec%0d_cnt", i),    32'(fill_cnt),  32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_sync", i),   32'(sync_err),  32'(vecs[i].exp_sync));
      chk($sformatf("vec%0d_wvalid", i), 32'(win_valid), 32'(vecs[i].exp_wvalid));
      chk($sformatf("vec%0d_iready", i), 32'(in_ready),  32'(vecs[i].exp_iready));
    end
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    win_ready = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    tick();

    // full window, no backpressure release
    feed_beats(0, 29, 1'b1);
    chk("full_pre_wvalid", 32'(win_valid), 32'd0);
    chk("full_pre_cnt",    32'(fill_cnt),  32'd29);
    feed_beats(29, 1, 1'b0);
    chk("full_wvalid",  32'(win_valid), 32'd1);
    chk("full_iready",  32'(in_ready),  32'd0);
    chk("full_cnt",     32'(fill_cnt),  32'd0);
    chk("full_state",   32'(dbg_state), 32'd1);
    chk("pix_0_0",   32'(win_buffer[0 +: 8]),             32'h00);
    chk("pix_0_8",   32'(win_buffer[8*8 +: 8]),           32'h08);
    chk("pix_0_14",  32'(win_buffer[14*8 +: 8]),          32'h0E);
    chk("pix_14_14", 32'(win_buffer[(14*15+14)*8 +: 8]),  32'hEE);
    check_window("full_window", 1'b0);

    // 20 idle cycles in FULL with junk beats offered
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_sof   = 1'($urandom_range(0, 1));
      in_data  = {$urandom(), $urandom()};
      tick();
    end
    chk("idle_wvalid", 32'(win_valid), 32'd1);
    chk("idle_cnt",    32'(fill_cnt),  32'd0);
    check_window("idle_stable", 1'b0);

    // handoff with in_valid held, then back-to-back windows
    in_sof    = 1'b0;
    in_valid  = 1'b1;
    in_data   = pat(0);
    win_ready = 1'b1;
    tick();
    chk("ho_wvalid", 32'(win_valid), 32'd0);
    chk("ho_iready", 32'(in_ready),  32'd1);
    chk("ho_cnt",    32'(fill_cnt),  32'd0);
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < 30; j++) begin
        in_data = pat(j);
        tick();
        if (j == 0) chk($sformatf("b2b%0d_first_cnt", w), 32'(fill_cnt), 32'd1);
        if (j == 28) chk($sformatf("b2b%0d_pre_wvalid", w), 32'(win_valid), 32'd0);
      end
      chk($sformatf("b2b%0d_wvalid", w), 32'(win_valid), 32'd1);
      check_window($sformatf("b2b%0d_window", w), 1'b0);
      in_data = pat(0);
      tick();
      chk($sformatf("b2b%0d_handoff", w), 32'(win_valid), 32'd0);
    end
    win_ready = 1'b0;
    in_valid  = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    tick();

    // alternating input gaps
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = (i % 2 == 0) ? pat(i / 2) : {$urandom(), $urandom()};
      tick();
      if (i % 2 == 0) cnt++;
      chk($sformatf("gap%0d_cnt", i), 32'(fill_cnt), 32'(cnt % 30));
      chk($sformatf("gap%0d_wvalid", i), 32'(win_valid), (cnt == 30) ? 32'd1 : 32'd0);
    end
    check_window("gap_window", 1'b0);
    handoff();

    // sof restart mid-fill
    feed_beats(0, 11, 1'b1);
    chk("sync_pre_cnt", 32'(fill_cnt), 32'd11);
    in_valid = 1'b1;
    in_sof   = 1'b1;
    in_data  = {8{8'hA5}};
    tick();
    in_sof = 1'b0;
    chk("sync_pulse", 32'(sync_err), 32'd1);
    chk("sync_cnt",   32'(fill_cnt), 32'd1);
    chk("sync_row0",  32'(win_buffer[31:0]),  32'hA5A5A5A5);
    chk("sync_row0b", 32'(win_buffer[63:32]), 32'hA5A5A5A5);
    feed_beats(1, 1, 1'b0);
    chk("sync_drop", 32'(sync_err), 32'd0);
    feed_beats(2, 28, 1'b0);
    chk("sync_wvalid", 32'(win_valid), 32'd1);
    chk("sync_in_full", 32'(sync_err), 32'd0);
    check_window("sync_window", 1'b1);
    handoff();

    // asynchronous reset mid-fill, then in FULL
    feed_beats(0, 17, 1'b1);
    chk("mid_pre_cnt", 32'(fill_cnt), 32'd17);
    #2 rst = 1'b0;
    #1 check_reset_state("mid_fill_async");
    tick();
    rst = 1'b1;
    feed_beats(0, 30, 1'b0);
    chk("mid_full_wvalid", 32'(win_valid), 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_state("mid_full_async");
    tick();
    rst = 1'b1;
    feed_beats(0, 30, 1'b1);
    chk("post_rst_wvalid", 32'(win_valid), 32'd1);
    check_window("post_rst_window", 1'b0);
    handoff();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
